// File: rtl/cb_arbiter_2x1.sv
// cb_arbiter_2x1: shares one core data bus between the LSU (master 0) and the
// debug/aux master (master 1). Read and write address channels are arbitrated
// independently (round robin with grant locking); ordering FIFOs route write
// data and responses back to the issuing master.
//
// Handshake rule on every channel: a transfer happens in the cycle where valid
// and ready are both high. A valid that has been raised stays high, with stable
// payload, until that transfer. Ready may depend combinationally on valid.

package cb_pkg;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_valid;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic [1:0]  wr_resp_error;
    logic        wr_resp_valid;
  } s_cb_miso_t;

endpackage

// Round-robin address-channel arbiter for two masters with grant locking.
module cb_arb_rr_lock (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic s_ready,
  input  logic blocked,
  output logic grant,
  output logic s_valid,
  output logic ready0,
  output logic ready1,
  output logic handshake
);

  logic prio_ff;
  logic lock_ff;
  logic lock_id_ff;
  logic grant_valid;

  // Pick the master: a locked grant wins, otherwise the pointer breaks ties.
  always_comb begin
    grant = 1'b0;
    if (lock_ff) begin
      grant = lock_id_ff;
    end else if (valid0 && valid1) begin
      grant = prio_ff;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

  assign grant_valid = grant ? valid1 : valid0;
  assign s_valid     = grant_valid && !blocked;
  assign handshake   = s_valid && s_ready;
  assign ready0      = !grant && valid0 && s_ready && !blocked;
  assign ready1      =  grant && valid1 && s_ready && !blocked;

  // Advance the pointer past the winner; hold the grant while it stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ff    <= 1'b0;
      lock_ff    <= 1'b0;
      lock_id_ff <= 1'b0;
    end else begin
      if (handshake) begin
        prio_ff <= ~grant;
      end
      lock_ff    <= s_valid && !s_ready;
      lock_id_ff <= grant;
    end
  end

endmodule

// Small FIFO of 1-bit master IDs that remembers transaction order.
module cb_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A full FIFO refuses a push even if it pops in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Top: two masters onto one core data bus.
module cb_arbiter_2x1
  import cb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t m0_mosi_i,
  output s_cb_miso_t m0_miso_o,
  input  s_cb_mosi_t m1_mosi_i,
  output s_cb_miso_t m1_miso_o,
  output s_cb_mosi_t s_mosi_o,
  input  s_cb_miso_t s_miso_i
);

  logic rd_grant, rd_s_valid, rd_ready0, rd_ready1, rd_hs;
  logic rd_head, rd_empty, rd_full, rd_pop;
  logic wr_grant, wr_s_valid, wr_ready0, wr_ready1, wr_hs;
  logic wd_head, wd_empty, wd_full, wd_pop;
  logic wr_head, wr_empty, wr_full, wr_pop;

  cb_arb_rr_lock u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .valid0    (m0_mosi_i.rd_addr_valid),
    .valid1    (m1_mosi_i.rd_addr_valid),
    .s_ready   (s_miso_i.rd_addr_ready),
    .blocked   (rd_full),
    .grant     (rd_grant),
    .s_valid   (rd_s_valid),
    .ready0    (rd_ready0),
    .ready1    (rd_ready1),
    .handshake (rd_hs)
  );

  cb_arb_rr_lock u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .valid0    (m0_mosi_i.wr_addr_valid),
    .valid1    (m1_mosi_i.wr_addr_valid),
    .s_ready   (s_miso_i.wr_addr_ready),
    .blocked   (wd_full || wr_full),
    .grant     (wr_grant),
    .s_valid   (wr_s_valid),
    .ready0    (wr_ready0),
    .ready1    (wr_ready1),
    .handshake (wr_hs)
  );

  cb_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
    .clk (clk), .rst (rst), .push (rd_hs), .din (rd_grant), .pop (rd_pop),
    .head (rd_head), .empty (rd_empty), .full (rd_full)
  );

  cb_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wdata_fifo (
    .clk (clk), .rst (rst), .push (wr_hs), .din (wr_grant), .pop (wd_pop),
    .head (wd_head), .empty (wd_empty), .full (wd_full)
  );

  cb_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wresp_fifo (
    .clk (clk), .rst (rst), .push (wr_hs), .din (wr_grant), .pop (wr_pop),
    .head (wr_head), .empty (wr_empty), .full (wr_full)
  );

  // Pops: responses with no owner are still consumed to keep the bus moving.
  assign rd_pop = s_miso_i.rd_valid &&
                  (rd_empty || (rd_head ? m1_mosi_i.rd_ready : m0_mosi_i.rd_ready));
  assign wd_pop = !wd_empty && s_miso_i.wr_data_ready &&
                  (wd_head ? m1_mosi_i.wr_data_valid : m0_mosi_i.wr_data_valid);
  assign wr_pop = s_miso_i.wr_resp_valid &&
                  (wr_empty || (wr_head ? m1_mosi_i.wr_resp_ready : m0_mosi_i.wr_resp_ready));

  // Steer requests to the slave and responses back to their owners.
  always_comb begin
    s_mosi_o  = '0;
    m0_miso_o = '0;
    m1_miso_o = '0;

    s_mosi_o.rd_addr         = rd_grant ? m1_mosi_i.rd_addr : m0_mosi_i.rd_addr;
    s_mosi_o.rd_size         = rd_grant ? m1_mosi_i.rd_size : m0_mosi_i.rd_size;
    s_mosi_o.rd_addr_valid   = rd_s_valid;
    m0_miso_o.rd_addr_ready  = rd_ready0;
    m1_miso_o.rd_addr_ready  = rd_ready1;

    if (rd_empty) begin
      s_mosi_o.rd_ready = 1'b1;
    end else if (rd_head) begin
      m1_miso_o.rd_data  = s_miso_i.rd_data;
      m1_miso_o.rd_resp  = s_miso_i.rd_resp;
      m1_miso_o.rd_valid = s_miso_i.rd_valid;
      s_mosi_o.rd_ready  = m1_mosi_i.rd_ready;
    end else begin
      m0_miso_o.rd_data  = s_miso_i.rd_data;
      m0_miso_o.rd_resp  = s_miso_i.rd_resp;
      m0_miso_o.rd_valid = s_miso_i.rd_valid;
      s_mosi_o.rd_ready  = m0_mosi_i.rd_ready;
    end

    s_mosi_o.wr_addr         = wr_grant ? m1_mosi_i.wr_addr : m0_mosi_i.wr_addr;
    s_mosi_o.wr_size         = wr_grant ? m1_mosi_i.wr_size : m0_mosi_i.wr_size;
    s_mosi_o.wr_addr_valid   = wr_s_valid;
    m0_miso_o.wr_addr_ready  = wr_ready0;
    m1_miso_o.wr_addr_ready  = wr_ready1;

    if (!wd_empty) begin
      if (wd_head) begin
        s_mosi_o.wr_data         = m1_mosi_i.wr_data;
        s_mosi_o.wr_strobe       = m1_mosi_i.wr_strobe;
        s_mosi_o.wr_data_valid   = m1_mosi_i.wr_data_valid;
        m1_miso_o.wr_data_ready  = s_miso_i.wr_data_ready;
      end else begin
        s_mosi_o.wr_data         = m0_mosi_i.wr_data;
        s_mosi_o.wr_strobe       = m0_mosi_i.wr_strobe;
        s_mosi_o.wr_data_valid   = m0_mosi_i.wr_data_valid;
        m0_miso_o.wr_data_ready  = s_miso_i.wr_data_ready;
      end
    end

    if (wr_empty) begin
      s_mosi_o.wr_resp_ready = 1'b1;
    end else if (wr_head) begin
      m1_miso_o.wr_resp_error = s_miso_i.wr_resp_error;
      m1_miso_o.wr_resp_valid = s_miso_i.wr_resp_valid;
      s_mosi_o.wr_resp_ready  = m1_mosi_i.wr_resp_ready;
    end else begin
      m0_miso_o.wr_resp_error = s_miso_i.wr_resp_error;
      m0_miso_o.wr_resp_valid = s_miso_i.wr_resp_valid;
      s_mosi_o.wr_resp_ready  = m0_mosi_i.wr_resp_ready;
    end
  end

endmodule

// File: tb/tb_cb_arbiter_2x1.sv
// Directed bench for cb_arbiter_2x1: reset values, read routing, round robin,
// grant locking, outstanding limit, write ordering, spurious responses, reset.
module tb_cb_arbiter_2x1;
  import cb_pkg::*;

  logic       clk;
  logic       rst;
  s_cb_mosi_t m0, m1, s_mosi;
  s_cb_miso_t m0_miso, m1_miso, s_miso;

  int n_cmp;
  int n_bad;

  cb_arbiter_2x1 #(.MAX_OUTSTANDING(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_mosi_i (m0),
    .m0_miso_o (m0_miso),
    .m1_mosi_i (m1),
    .m1_miso_o (m1_miso),
    .s_mosi_o  (s_mosi),
    .s_miso_i  (s_miso)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m0     = '0;
    m1     = '0;
    s_miso = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (s_mosi.rd_addr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_addr_valid: got %0b want 0", s_mosi.rd_addr_valid); end
    n_cmp++; if (s_mosi.wr_addr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_addr_valid: got %0b want 0", s_mosi.wr_addr_valid); end
    n_cmp++; if (s_mosi.wr_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_data_valid: got %0b want 0", s_mosi.wr_data_valid); end
    n_cmp++; if (s_mosi.rd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rd_ready: got %0b want 1", s_mosi.rd_ready); end
    n_cmp++; if (s_mosi.wr_resp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_resp_ready: got %0b want 1", s_mosi.wr_resp_ready); end
    n_cmp++; if ({m0_miso.rd_valid, m1_miso.rd_valid, m0_miso.wr_resp_valid, m1_miso.wr_resp_valid} !== 4'b0000) begin n_bad++; $display("FAIL reset_master_valids: got %b want 0000", {m0_miso.rd_valid, m1_miso.rd_valid, m0_miso.wr_resp_valid, m1_miso.wr_resp_valid}); end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m0.rd_addr = 32'h1000; m0.rd_size = 2'd2; m0.rd_addr_valid = 1'b1; m0.rd_ready = 1'b1;
    s_miso.rd_addr_ready = 1'b1;
    #1;
    n_cmp++; if (s_mosi.rd_addr_valid !== 1'b1) begin n_bad++; $display("FAIL single_s_valid: got %0b want 1", s_mosi.rd_addr_valid); end
    n_cmp++; if (s_mosi.rd_addr !== 32'h1000) begin n_bad++; $display("FAIL single_s_addr: got %h want 00001000", s_mosi.rd_addr); end
    n_cmp++; if (m0_miso.rd_addr_ready !== 1'b1) begin n_bad++; $display("FAIL single_m0_ready: got %0b want 1", m0_miso.rd_addr_ready); end
    tick();
    m0.rd_addr_valid = 1'b0;
    s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'hDEADBEEF; s_miso.rd_resp = 2'd0;
    #1;
    n_cmp++; if (m0_miso.rd_valid !== 1'b1) begin n_bad++; $display("FAIL single_m0_rd_valid: got %0b want 1", m0_miso.rd_valid); end
    n_cmp++; if (m0_miso.rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_m0_rd_data: got %h want deadbeef", m0_miso.rd_data); end
    n_cmp++; if (m1_miso.rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_m1_rd_valid: got %0b want 0", m1_miso.rd_valid); end
    tick();
    s_miso.rd_valid = 1'b0; m0.rd_ready = 1'b0;
    #1;
    n_cmp++; if (s_mosi.rd_ready !== 1'b1) begin n_bad++; $display("FAIL single_fifo_empty: s rd_ready got %0b want 1", s_mosi.rd_ready); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] a0_tab   [4] = '{32'hA0, 32'hA0, 32'hA4, 32'hA4};
    logic [31:0] a1_tab   [4] = '{32'hB0, 32'hB0, 32'hB4, 32'hB4};
    logic [31:0] exp_addr [4] = '{32'hA0, 32'hB0, 32'hA4, 32'hB4};
    logic        exp_gnt  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] rsp_data [4] = '{32'hD00000A0, 32'hD00000B0, 32'hD00000A4, 32'hD00000B4};
    do_reset();
    m0.rd_ready = 1'b1; m1.rd_ready = 1'b1; s_miso.rd_addr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      m0.rd_addr_valid = (k < 4); m1.rd_addr_valid = (k < 4);
      if (k < 4) begin m0.rd_addr = a0_tab[k]; m1.rd_addr = a1_tab[k]; end
      s_miso.rd_valid = (k > 0);
      if (k > 0) s_miso.rd_data = rsp_data[k-1];
      #1;
      if (k < 4) begin
        n_cmp++; if (s_mosi.rd_addr !== exp_addr[k]) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h want %h", k, s_mosi.rd_addr, exp_addr[k]); end
        n_cmp++; if ({m1_miso.rd_addr_ready, m0_miso.rd_addr_ready} !== (exp_gnt[k] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_grant[%0d]: got readies %b want grant %0d", k, {m1_miso.rd_addr_ready, m0_miso.rd_addr_ready}, exp_gnt[k]); end
      end
      if (k > 0) begin
        n_cmp++; if ({m1_miso.rd_valid, m0_miso.rd_valid} !== (exp_gnt[k-1] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_resp_route[%0d]: got %b want master %0d", k, {m1_miso.rd_valid, m0_miso.rd_valid}, exp_gnt[k-1]); end
        n_cmp++; if ((exp_gnt[k-1] ? m1_miso.rd_data : m0_miso.rd_data) !== rsp_data[k-1]) begin n_bad++; $display("FAIL rr_resp_data[%0d]: got %h want %h", k, exp_gnt[k-1] ? m1_miso.rd_data : m0_miso.rd_data, rsp_data[k-1]); end
      end
      tick();
    end
    s_miso.rd_valid = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    m0.rd_ready = 1'b1; m1.rd_ready = 1'b1;
    // one m0 read first so that the pointer prefers m1
    m0.rd_addr = 32'h200; m0.rd_addr_valid = 1'b1; s_miso.rd_addr_ready = 1'b1;
    tick();
    m0.rd_addr_valid = 1'b0; s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'h222;
    tick();
    s_miso.rd_valid = 1'b0;
    m0.rd_addr = 32'h300; m0.rd_addr_valid = 1'b1; s_miso.rd_addr_ready = 1'b0;
    #1;
    n_cmp++; if (s_mosi.rd_addr !== 32'h300 || s_mosi.rd_addr_valid !== 1'b1) begin n_bad++; $display("FAIL lock_c0: got addr %h valid %0b want 300/1", s_mosi.rd_addr, s_mosi.rd_addr_valid); end
    tick();
    for (int c = 1; c < 3; c++) begin
      m1.rd_addr = 32'h400; m1.rd_addr_valid = 1'b1;
      #1;
      n_cmp++; if (s_mosi.rd_addr !== 32'h300) begin n_bad++; $display("FAIL lock_hold[%0d]: got %h want 00000300", c, s_mosi.rd_addr); end
      n_cmp++; if (m1_miso.rd_addr_ready !== 1'b0) begin n_bad++; $display("FAIL lock_m1_ready[%0d]: got %0b want 0", c, m1_miso.rd_addr_ready); end
      tick();
    end
    s_miso.rd_addr_ready = 1'b1;
    #1;
    n_cmp++; if (s_mosi.rd_addr !== 32'h300 || m0_miso.rd_addr_ready !== 1'b1) begin n_bad++; $display("FAIL lock_accept: got addr %h m0 ready %0b want 300/1", s_mosi.rd_addr, m0_miso.rd_addr_ready); end
    tick();
    m0.rd_addr_valid = 1'b0;
    #1;
    n_cmp++; if (s_mosi.rd_addr !== 32'h400 || m1_miso.rd_addr_ready !== 1'b1) begin n_bad++; $display("FAIL lock_switch: got addr %h m1 ready %0b want 400/1", s_mosi.rd_addr, m1_miso.rd_addr_ready); end
    tick();
    m1.rd_addr_valid = 1'b0; s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'h333;
    #1;
    n_cmp++; if ({m1_miso.rd_valid, m0_miso.rd_valid} !== 2'b01 || m0_miso.rd_data !== 32'h333) begin n_bad++; $display("FAIL lock_resp0: got valids %b data %h want 01/333", {m1_miso.rd_valid, m0_miso.rd_valid}, m0_miso.rd_data); end
    tick();
    s_miso.rd_data = 32'h444;
    #1;
    n_cmp++; if ({m1_miso.rd_valid, m0_miso.rd_valid} !== 2'b10 || m1_miso.rd_data !== 32'h444) begin n_bad++; $display("FAIL lock_resp1: got valids %b data %h want 10/444", {m1_miso.rd_valid, m0_miso.rd_valid}, m1_miso.rd_data); end
    tick();
    s_miso.rd_valid = 1'b0;
  endtask

  task automatic test_outstanding();
    do_reset();
    s_miso.rd_addr_ready = 1'b1; m0.rd_ready = 1'b1; m1.rd_ready = 1'b1;
    m0.rd_addr = 32'h600; m0.rd_addr_valid = 1'b1;
    tick();
    m0.rd_addr = 32'h604;
    #1;
    n_cmp++; if (m0_miso.rd_addr_ready !== 1'b1) begin n_bad++; $display("FAIL out_second_accept: got %0b want 1", m0_miso.rd_addr_ready); end
    tick();
    m0.rd_addr_valid = 1'b0; m1.rd_addr = 32'h700; m1.rd_addr_valid = 1'b1;
    #1;
    n_cmp++; if (s_mosi.rd_addr_valid !== 1'b0 || m1_miso.rd_addr_ready !== 1'b0) begin n_bad++; $display("FAIL out_full_block: got valid %0b ready %0b want 0/0", s_mosi.rd_addr_valid, m1_miso.rd_addr_ready); end
    tick();
    s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'h6000;
    #1;
    n_cmp++; if (m1_miso.rd_addr_ready !== 1'b0) begin n_bad++; $display("FAIL out_full_pop_same_cycle: got %0b want 0", m1_miso.rd_addr_ready); end
    n_cmp++; if (m0_miso.rd_valid !== 1'b1 || m0_miso.rd_data !== 32'h6000) begin n_bad++; $display("FAIL out_resp_a: got %0b/%h want 1/6000", m0_miso.rd_valid, m0_miso.rd_data); end
    tick();
    s_miso.rd_data = 32'h6040;
    #1;
    n_cmp++; if (m1_miso.rd_addr_ready !== 1'b1 || s_mosi.rd_addr !== 32'h700) begin n_bad++; $display("FAIL out_accept_after_pop: got ready %0b addr %h want 1/700", m1_miso.rd_addr_ready, s_mosi.rd_addr); end
    n_cmp++; if (m0_miso.rd_valid !== 1'b1 || m0_miso.rd_data !== 32'h6040) begin n_bad++; $display("FAIL out_resp_b: got %0b/%h want 1/6040", m0_miso.rd_valid, m0_miso.rd_data); end
    tick();
    m1.rd_addr_valid = 1'b0; s_miso.rd_data = 32'h7000;
    #1;
    n_cmp++; if ({m1_miso.rd_valid, m0_miso.rd_valid} !== 2'b10 || m1_miso.rd_data !== 32'h7000) begin n_bad++; $display("FAIL out_resp_c: got valids %b data %h want 10/7000", {m1_miso.rd_valid, m0_miso.rd_valid}, m1_miso.rd_data); end
    tick();
    s_miso.rd_valid = 1'b0;
  endtask

  task automatic test_write();
    do_reset();
    s_miso.wr_addr_ready = 1'b1; s_miso.wr_data_ready = 1'b1;
    m0.wr_resp_ready = 1'b1; m1.wr_resp_ready = 1'b1;
    m1.wr_addr = 32'h20; m1.wr_addr_valid = 1'b1;
    m1.wr_data = 32'h11111111; m1.wr_strobe = 4'b0011; m1.wr_data_valid = 1'b1;
    #1;
    n_cmp++; if (s_mosi.wr_addr !== 32'h20 || m1_miso.wr_addr_ready !== 1'b1) begin n_bad++; $display("FAIL wr_addr_m1: got addr %h ready %0b want 20/1", s_mosi.wr_addr, m1_miso.wr_addr_ready); end
    n_cmp++; if (s_mosi.wr_data_valid !== 1'b0 || m1_miso.wr_data_ready !== 1'b0) begin n_bad++; $display("FAIL wr_data_early: got valid %0b ready %0b want 0/0", s_mosi.wr_data_valid, m1_miso.wr_data_ready); end
    tick();
    m1.wr_addr_valid = 1'b0; m0.wr_addr = 32'h40; m0.wr_addr_valid = 1'b1;
    m0.wr_data = 32'h22222222; m0.wr_strobe = 4'b1111; m0.wr_data_valid = 1'b1;
    #1;
    n_cmp++; if (s_mosi.wr_addr !== 32'h40 || m0_miso.wr_addr_ready !== 1'b1) begin n_bad++; $display("FAIL wr_addr_m0: got addr %h ready %0b want 40/1", s_mosi.wr_addr, m0_miso.wr_addr_ready); end
    n_cmp++; if (s_mosi.wr_data !== 32'h11111111 || s_mosi.wr_strobe !== 4'b0011 || s_mosi.wr_data_valid !== 1'b1) begin n_bad++; $display("FAIL wr_data_first: got %h/%b/%0b want 11111111/0011/1", s_mosi.wr_data, s_mosi.wr_strobe, s_mosi.wr_data_valid); end
    n_cmp++; if ({m1_miso.wr_data_ready, m0_miso.wr_data_ready} !== 2'b10) begin n_bad++; $display("FAIL wr_data_ready_first: got %b want 10", {m1_miso.wr_data_ready, m0_miso.wr_data_ready}); end
    tick();
    m0.wr_addr_valid = 1'b0; m1.wr_data_valid = 1'b0;
    s_miso.wr_resp_valid = 1'b1; s_miso.wr_resp_error = 2'd0;
    #1;
    n_cmp++; if (s_mosi.wr_data !== 32'h22222222 || s_mosi.wr_strobe !== 4'b1111 || m0_miso.wr_data_ready !== 1'b1) begin n_bad++; $display("FAIL wr_data_second: got %h/%b ready %0b want 22222222/1111/1", s_mosi.wr_data, s_mosi.wr_strobe, m0_miso.wr_data_ready); end
    n_cmp++; if ({m1_miso.wr_resp_valid, m0_miso.wr_resp_valid} !== 2'b10 || m1_miso.wr_resp_error !== 2'd0) begin n_bad++; $display("FAIL wr_resp_m1: got valids %b err %0d want 10/0", {m1_miso.wr_resp_valid, m0_miso.wr_resp_valid}, m1_miso.wr_resp_error); end
    tick();
    m0.wr_data_valid = 1'b0;
    #1;
    n_cmp++; if ({m1_miso.wr_resp_valid, m0_miso.wr_resp_valid} !== 2'b01 || m0_miso.wr_resp_error !== 2'd0) begin n_bad++; $display("FAIL wr_resp_m0: got valids %b err %0d want 01/0", {m1_miso.wr_resp_valid, m0_miso.wr_resp_valid}, m0_miso.wr_resp_error); end
    n_cmp++; if (s_mosi.wr_data_valid !== 1'b0) begin n_bad++; $display("FAIL wr_data_drained: got %0b want 0", s_mosi.wr_data_valid); end
    tick();
    s_miso.wr_resp_valid = 1'b0; m0.wr_resp_ready = 1'b0; m1.wr_resp_ready = 1'b0;
    #1;
    n_cmp++; if (s_mosi.wr_resp_ready !== 1'b1) begin n_bad++; $display("FAIL wr_resp_fifo_empty: got %0b want 1", s_mosi.wr_resp_ready); end
    tick();
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    s_miso.rd_valid = 1'b1; s_miso.rd_data = 32'hBAD; s_miso.wr_resp_valid = 1'b1;
    #1;
    n_cmp++; if (s_mosi.rd_ready !== 1'b1 || {m1_miso.rd_valid, m0_miso.rd_valid} !== 2'b00) begin n_bad++; $display("FAIL spur_rd: got ready %0b valids %b want 1/00", s_mosi.rd_ready, {m1_miso.rd_valid, m0_miso.rd_valid}); end
    n_cmp++; if (s_mosi.wr_resp_ready !== 1'b1 || {m1_miso.wr_resp_valid, m0_miso.wr_resp_valid} !== 2'b00) begin n_bad++; $display("FAIL spur_wr: got ready %0b valids %b want 1/00", s_mosi.wr_resp_ready, {m1_miso.wr_resp_valid, m0_miso.wr_resp_valid}); end
    tick();
    s_miso.rd_valid = 1'b0; s_miso.wr_resp_valid = 1'b0;
    m0.rd_addr = 32'h500; m0.rd_addr_valid = 1'b1; s_miso.rd_addr_ready = 1'b1;
    tick();
    m0.rd_addr_valid = 1'b0;
    m1.wr_addr = 32'h60; m1.wr_addr_valid = 1'b1; s_miso.wr_addr_ready = 1'b1;
    tick();
    m1.wr_addr_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; m1.wr_data_valid = 1'b1; s_miso.wr_data_ready = 1'b1;
    #1;
    n_cmp++; if (s_mosi.wr_data_valid !== 1'b0 || m1_miso.wr_data_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wdata_cleared: got valid %0b ready %0b want 0/0", s_mosi.wr_data_valid, m1_miso.wr_data_ready); end
    n_cmp++; if (s_mosi.rd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rd_fifo_cleared: got %0b want 1", s_mosi.rd_ready); end
    n_cmp++; if (s_mosi.wr_resp_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wresp_fifo_cleared: got %0b want 1", s_mosi.wr_resp_ready); end
    n_cmp++; if (s_mosi.rd_addr_valid !== 1'b0 || s_mosi.wr_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_addr_valids: got %0b/%0b want 0/0", s_mosi.rd_addr_valid, s_mosi.wr_addr_valid); end
    tick();
    m1.wr_data_valid = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    m0 = '0;
    m1 = '0;
    s_miso = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_write();
    test_spurious_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
